// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame mode encoding and the
// parity function used by both the receive checker and the transmit generator.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Frame mode, packed as {eight, p_en, ohel}
    typedef struct packed {
        logic eight;
        logic p_en;
        logic ohel;
    } uart_mode_t;

    // Parity over 7 or 8 data bits; odd=1 inverts the even parity
    function automatic logic calc_parity(input logic [7:0] data,
                                         input logic       eight,
                                         input logic       odd);
        logic [7:0] masked;
        masked = data & {eight, 7'h7f};
        return (^masked) ^ odd;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Loadable bit-period down-counter. Loads k or k>>1 and raises done for one
// cycle when the count is about to expire, so an action taken on done lands
// exactly 'load value' cycles after the load.
module rx_bit_timer #(
    parameter int BAUD_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              half,
    input  logic [BAUD_W-1:0] k,
    output logic              done
);

    logic [BAUD_W-1:0] cnt;

    // Count down to zero and stop; a load always wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= half ? (k >> 1) : k;
        end else if (cnt != '0) begin
            cnt <= cnt - BAUD_W'(1);
        end
    end

    assign done = (cnt == BAUD_W'(1));

endmodule

// File: rtl/rx_engine.sv
// UART receive engine: start detect with mid-bit resample, 7/8 data bits,
// optional odd/even parity, one stop bit, with ready/parity/framing/overflow
// flags. Define RX_ENGINE_SYNC_EN to add a two-flop synchronizer on rx.
module rx_engine
    import uart_pkg::*;
#(
    parameter int BAUD_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic [BAUD_W-1:0] k,
    input  logic              eight,
    input  logic              p_en,
    input  logic              ohel,
    input  logic              read,
    output logic [7:0]        rx_data,
    output logic              rxrdy,
    output logic              perr,
    output logic              ferr,
    output logic              ovf
);

    logic       rx_s;
    rx_state_t  state;
    uart_mode_t mode;
    logic [8:0] bits;
    logic [3:0] bit_idx;
    logic [3:0] last_idx;
    logic       t_load;
    logic       t_half;
    logic       t_done;
    logic       complete;
    logic [7:0] rx_byte;
    logic       par_rx;
    logic       par_bad;

`ifdef RX_ENGINE_SYNC_EN
    logic sync1;
    logic sync2;

    // Two-flop synchronizer, idle-high out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
        end
    end

    assign rx_s = sync2;
`else
    assign rx_s = rx;
`endif

    rx_bit_timer #(.BAUD_W(BAUD_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (t_load),
        .half  (t_half),
        .k     (k),
        .done  (t_done)
    );

    // Index of the final data/parity bit: 7 + eight + p_en bits in total
    assign last_idx = 4'd6 + {3'b000, mode.eight} + {3'b000, mode.p_en};

    // Timer reload points: half period on start detect, full period afterwards
    always_comb begin
        t_load = 1'b0;
        t_half = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    t_load = 1'b1;
                    t_half = 1'b1;
                end
            end
            ST_START: begin
                if (t_done && !rx_s) t_load = 1'b1;
            end
            ST_DATA: begin
                if (t_done) t_load = 1'b1;
            end
            default: begin
                t_load = 1'b0;
            end
        endcase
    end

    // Frame sequencing and bit capture; mode is latched at start detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            bits    <= '0;
            mode    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state   <= ST_START;
                        mode    <= '{eight: eight, p_en: p_en, ohel: ohel};
                        bit_idx <= '0;
                    end
                end
                ST_START: begin
                    if (t_done) state <= rx_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (t_done) begin
                        bits[bit_idx] <= rx_s;
                        if (bit_idx == last_idx) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    if (t_done) begin
                        state   <= ST_IDLE;
                        bit_idx <= '0;
                    end
                end
            endcase
        end
    end

    assign complete = (state == ST_STOP) && t_done;
    assign rx_byte  = mode.eight ? bits[7:0] : {1'b0, bits[6:0]};
    assign par_rx   = mode.eight ? bits[8] : bits[7];
    assign par_bad  = mode.p_en && (par_rx != calc_parity(rx_byte, mode.eight, mode.ohel));

    // Output register: completion overrides a simultaneous read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data <= 8'h00;
            rxrdy   <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end else if (complete) begin
            rx_data <= rx_byte;
            rxrdy   <= 1'b1;
            perr    <= par_bad;
            ferr    <= ~rx_s;
            ovf     <= rxrdy & ~read;
        end else if (read) begin
            rxrdy   <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_engine.sv
// Directed testbench for rx_engine at k=16.
module tb_rx_engine;

    localparam int BAUD_W = 19;
    localparam int K      = 16;
`ifdef RX_ENGINE_SYNC_EN
    localparam int LAT    = K / 2 + 2;
`else
    localparam int LAT    = K / 2;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx = 1'b1;
    logic [BAUD_W-1:0] k = BAUD_W'(K);
    logic              eight = 1'b1;
    logic              p_en = 1'b0;
    logic              ohel = 1'b0;
    logic              read = 1'b0;
    logic [7:0]        rx_data;
    logic              rxrdy;
    logic              perr;
    logic              ferr;
    logic              ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    rx_engine #(.BAUD_W(BAUD_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .k       (k),
        .eight   (eight),
        .p_en    (p_en),
        .ohel    (ohel),
        .read    (read),
        .rx_data (rx_data),
        .rxrdy   (rxrdy),
        .perr    (perr),
        .ferr    (ferr),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hold rx at v for n cycles, sampled at negedges
    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pulse_read();
        read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
    endtask

    // One frame; lat = cycle index within the stop bit at which rxrdy first
    // reads 1 (-1 if rxrdy was already high or never rose)
    task automatic send_frame(input logic [7:0] d, input int nbits,
                              input logic has_par, input logic par,
                              input logic stop, output int l);
        logic was;
        drive(1'b0, K);
        for (int i = 0; i < nbits; i++) drive(d[i], K);
        if (has_par) drive(par, K);
        l   = -1;
        was = rxrdy;
        rx  = stop;
        for (int i = 0; i < K; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!was && rxrdy && l < 0) l = i;
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rxrdy", rxrdy, 1'b0);
        check("reset_perr", perr, 1'b0);
        check("reset_ferr", ferr, 1'b0);
        check("reset_ovf", ovf, 1'b0);
        reset = 1'b0;
        drive(1'b1, 4);

        // 8N1 0xA5
        eight = 1'b1; p_en = 1'b0; ohel = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, lat);
        check("a5_latency", lat, LAT);
        check("a5_rxrdy", rxrdy, 1'b1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_perr", perr, 1'b0);
        check("a5_ferr", ferr, 1'b0);
        check("a5_ovf", ovf, 1'b0);
        pulse_read();
        check("a5_read_clears", rxrdy, 1'b0);
        drive(1'b1, K);

        // 7E1 0x35, wrong parity then right parity
        eight = 1'b0; p_en = 1'b1; ohel = 1'b0;
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, lat);
        check("7e1_bad_data", rx_data, 8'h35);
        check("7e1_bad_perr", perr, 1'b1);
        pulse_read();
        check("7e1_read_perr", perr, 1'b0);
        drive(1'b1, K);
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, lat);
        check("7e1_good_data", rx_data, 8'h35);
        check("7e1_good_perr", perr, 1'b0);
        check("7e1_good_ovf", ovf, 1'b0);
        pulse_read();
        drive(1'b1, K);

        // 8O1 0x00 with correct parity (1) and a zero stop bit
        eight = 1'b1; p_en = 1'b1; ohel = 1'b1;
        send_frame(8'h00, 8, 1'b1, 1'b1, 1'b0, lat);
        drive(1'b1, K);
        check("8o1_ferr", ferr, 1'b1);
        check("8o1_perr", perr, 1'b0);
        check("8o1_data", rx_data, 8'h00);
        check("8o1_rxrdy", rxrdy, 1'b1);

        // False start: flags from the previous frame must survive
        drive(1'b0, 4);
        drive(1'b1, 3 * K);
        check("false_rxrdy", rxrdy, 1'b1);
        check("false_ferr", ferr, 1'b1);
        check("false_data", rx_data, 8'h00);
        pulse_read();

        // Back-to-back 8N1 without read
        eight = 1'b1; p_en = 1'b0; ohel = 1'b0;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, lat);
        check("b2b1_data", rx_data, 8'h11);
        check("b2b1_ovf", ovf, 1'b0);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, lat);
        check("b2b2_data", rx_data, 8'h22);
        check("b2b2_ovf", ovf, 1'b1);
        check("b2b2_rxrdy", rxrdy, 1'b1);
        pulse_read();
        check("b2b_read_ovf", ovf, 1'b0);
        drive(1'b1, K);

        // Reset in the middle of a 0xFF frame, then a clean 0x5A frame
        drive(1'b0, K);
        drive(1'b1, 3 * K);
        reset = 1'b1;
        drive(1'b1, 2);
        reset = 1'b0;
        drive(1'b1, 8 * K);
        check("rst_mid_data", rx_data, 8'h00);
        check("rst_mid_rxrdy", rxrdy, 1'b0);
        check("rst_mid_flags", {perr, ferr, ovf}, 3'b000);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, lat);
        check("post_rst_data", rx_data, 8'h5A);
        check("post_rst_rxrdy", rxrdy, 1'b1);
        check("post_rst_flags", {perr, ferr, ovf}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_engine.md
RX_ENGINE -- requirements
Module: rx_engine

Interface
REQ-001 Parameter BAUD_W, default 19, width of bit-period count input k.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx  input  1  serial line, idle high.
REQ-005 k  input  BAUD_W  bit period in clk cycles; legal k >= 4; held stable during a frame.
REQ-006 eight  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-007 p_en  input  1  1 = parity bit present.
REQ-008 ohel  input  1  parity sense when p_en=1: 1 = odd, 0 = even.
REQ-009 read  input  1  one-cycle pulse; consumer took rx_data; clears rxrdy and error flags.
REQ-010 rx_data  output  8  received byte; bit 7 forced 0 in 7-bit modes.
REQ-011 rxrdy  output  1  frame complete, data valid.
REQ-012 perr  output  1  parity error on last frame.
REQ-013 ferr  output  1  framing error (stop bit sampled 0) on last frame.
REQ-014 ovf  output  1  frame completed while rxrdy was still 1.

Function
REQ-015 Frame: start(0), data LSB first (7 or 8), parity if p_en, one stop(1); bits after start N = 7 + eight + p_en + 1.
REQ-016 FSM states IDLE, START, DATA, STOP; IDLE -> START on rx=0 sampled in IDLE.
REQ-017 START: wait k>>1 cycles, resample rx; rx=1 -> IDLE (false start, no flags touched); rx=0 -> DATA, bit timer reloaded to k.
REQ-018 DATA: sample rx every k cycles into bit index 0..N-2 (data then parity); after the last of these -> STOP.
REQ-019 STOP: sample rx after k cycles; next cycle assert rxrdy, load rx_data, perr, ferr, ovf; return to IDLE same cycle.
REQ-020 Computed parity = XOR of the 7 or 8 received data bits, inverted when ohel=1; perr = p_en AND (received parity != computed); perr=0 when p_en=0.
REQ-021 ferr = 1 when stop sample is 0; frame still completes and rxrdy still asserts.
REQ-022 ovf = 1 when completion occurs with rxrdy already 1; rx_data overwritten with new byte.
REQ-023 read clears rxrdy, perr, ferr, ovf next cycle; read coincident with completion: completion wins, flags reflect new frame (ovf=0 since old data consumed).
REQ-024 eight, p_en, ohel sampled on IDLE -> START and held internally for the frame.
REQ-025 Back-to-back frames: new start detected from IDLE the cycle after STOP completion; no missed start when stop length is exactly k.
REQ-026 Latency: rxrdy rises 1 cycle after stop sample point (plus synchronizer delay, REQ-030).

Reset
REQ-027 reset asserted: state IDLE, timer and bit index 0, rx_data=8'h00, rxrdy=perr=ferr=ovf=0, synchronizer flops=1.
REQ-028 reset mid-frame aborts frame with no output update; after release, engine waits for next rx falling edge.

Configuration
REQ-029 Macro RX_ENGINE_SYNC_EN selects input synchronization.
REQ-030 Defined: rx passes through two flops reset to 1; all sampling uses synchronized rx; 2-cycle added latency.
REQ-031 Undefined: rx used directly; rx must already be synchronous to clk.

Structure
REQ-032 Shared package uart_pkg: FSM state enum, mode encoding {eight,p_en,ohel}, parity function (even/odd over 7/8 bits), shared with transmit-side parity generator.
REQ-033 One sub-module rx_bit_timer: loadable down-counter of width BAUD_W, load value k or k>>1, one-cycle done pulse.

Verification
REQ-034 k=16, 8N1, send 0xA5 -> rxrdy=1, rx_data=8'hA5, perr=ferr=ovf=0; read -> rxrdy=0 next cycle.
REQ-035 k=16, 7E1, send 0x35 with parity bit 1 (correct is 0) -> rx_data=8'h35, perr=1; repeat with parity 0 -> perr=0.
REQ-036 k=16, 8O1, send 0x00 with stop bit 0 -> ferr=1, perr=0, rx_data=8'h00.
REQ-037 k=16, rx low 4 cycles then high -> no rxrdy, FSM back in IDLE, flags unchanged.
REQ-038 Two 8N1 frames 0x11, 0x22 without read -> second completion ovf=1, rx_data=8'h22.
REQ-039 reset pulsed mid-data of 0xFF frame -> all outputs 0; next clean frame 0x5A received correctly.
